// File: rtl/ex_mem_reg.sv
// rtl/ex_mem_reg.sv - EX->MEM pipeline register with signed-overflow trap FSM
module ex_mem_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              ex_valid_i,
    input  logic [DATA_W-1:0] ex_pc_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_overflow_i,
    input  logic              ovf_trap_en_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic              reg_write_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              mem_to_reg_i,
    input  logic              exc_ack_i,
    output logic              mem_valid_o,
    output logic [DATA_W-1:0] mem_alu_result_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [REG_AW-1:0] mem_rd_addr_o,
    output logic              mem_reg_write_o,
    output logic              mem_mem_read_o,
    output logic              mem_mem_write_o,
    output logic              mem_mem_to_reg_o,
    output logic              exc_o,
    output logic [DATA_W-1:0] epc_o,
    output logic              exc_pending_o
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_TRAP = 1'b1;

    logic [0:0] state;
    logic       trap_hit;
    logic       load_bubble;
    logic       load_insn;

    // Decide what the pipeline register loads this edge: flush beats stall beats the FSM
    always_comb begin
        trap_hit    = 1'b0;
        load_bubble = 1'b0;
        load_insn   = 1'b0;
        if (flush_i) begin
            load_bubble = 1'b1;
        end else if (!stall_i) begin
            if (state == ST_TRAP) begin
                load_bubble = 1'b1;
            end else if (ex_valid_i && ovf_trap_en_i && alu_overflow_i) begin
                trap_hit    = 1'b1;
                load_bubble = 1'b1;
            end else begin
                load_insn = 1'b1;
            end
        end
    end

    // Pipeline payload: bubbles clear everything, stalls hold, captures gate write controls by valid
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid_o      <= 1'b0;
            mem_alu_result_o <= '0;
            mem_wdata_o      <= '0;
            mem_rd_addr_o    <= '0;
            mem_reg_write_o  <= 1'b0;
            mem_mem_read_o   <= 1'b0;
            mem_mem_write_o  <= 1'b0;
            mem_mem_to_reg_o <= 1'b0;
        end else if (load_bubble) begin
            mem_valid_o      <= 1'b0;
            mem_alu_result_o <= '0;
            mem_wdata_o      <= '0;
            mem_rd_addr_o    <= '0;
            mem_reg_write_o  <= 1'b0;
            mem_mem_read_o   <= 1'b0;
            mem_mem_write_o  <= 1'b0;
            mem_mem_to_reg_o <= 1'b0;
        end else if (load_insn) begin
            mem_valid_o      <= ex_valid_i;
            mem_alu_result_o <= alu_result_i;
            mem_wdata_o      <= rt_data_i;
            mem_rd_addr_o    <= rd_addr_i;
            mem_reg_write_o  <= reg_write_i & ex_valid_i;
            mem_mem_read_o   <= mem_read_i & ex_valid_i;
            mem_mem_write_o  <= mem_write_i & ex_valid_i;
            mem_mem_to_reg_o <= mem_to_reg_i;
        end
    end

    // Trap FSM: RUN traps on signed overflow, TRAP squashes until the handler acknowledges
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            exc_o <= 1'b0;
            epc_o <= '0;
        end else if (flush_i || stall_i) begin
            exc_o <= 1'b0;
        end else if (state == ST_TRAP) begin
            exc_o <= 1'b0;
            if (exc_ack_i) begin
                state <= ST_RUN;
            end
        end else if (trap_hit) begin
            state <= ST_TRAP;
            exc_o <= 1'b1;
            epc_o <= ex_pc_i;
        end else begin
            exc_o <= 1'b0;
        end
    end

    assign exc_pending_o = (state == ST_TRAP);

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb/tb_ex_mem_reg.sv - directed self-checking bench for ex_mem_reg
module tb_ex_mem_reg;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        stall_i, flush_i, ex_valid_i;
    logic [31:0] ex_pc_i, alu_result_i, rt_data_i;
    logic        alu_overflow_i, ovf_trap_en_i;
    logic [4:0]  rd_addr_i;
    logic        reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i, exc_ack_i;
    logic        mem_valid_o;
    logic [31:0] mem_alu_result_o, mem_wdata_o, epc_o;
    logic [4:0]  mem_rd_addr_o;
    logic        mem_reg_write_o, mem_mem_read_o, mem_mem_write_o, mem_mem_to_reg_o;
    logic        exc_o, exc_pending_o;

    int errors = 0;
    int checks = 0;

    ex_mem_reg #(.DATA_W(32), .REG_AW(5)) dut (
        .clk_i(clk_i), .rst_n(rst_n), .stall_i(stall_i), .flush_i(flush_i),
        .ex_valid_i(ex_valid_i), .ex_pc_i(ex_pc_i), .alu_result_i(alu_result_i),
        .alu_overflow_i(alu_overflow_i), .ovf_trap_en_i(ovf_trap_en_i),
        .rt_data_i(rt_data_i), .rd_addr_i(rd_addr_i), .reg_write_i(reg_write_i),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .mem_to_reg_i(mem_to_reg_i),
        .exc_ack_i(exc_ack_i), .mem_valid_o(mem_valid_o),
        .mem_alu_result_o(mem_alu_result_o), .mem_wdata_o(mem_wdata_o),
        .mem_rd_addr_o(mem_rd_addr_o), .mem_reg_write_o(mem_reg_write_o),
        .mem_mem_read_o(mem_mem_read_o), .mem_mem_write_o(mem_mem_write_o),
        .mem_mem_to_reg_o(mem_mem_to_reg_o), .exc_o(exc_o), .epc_o(epc_o),
        .exc_pending_o(exc_pending_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        stall_i = 0; flush_i = 0; ex_valid_i = 0; ex_pc_i = 0; alu_result_i = 0;
        alu_overflow_i = 0; ovf_trap_en_i = 0; rt_data_i = 0; rd_addr_i = 0;
        reg_write_i = 0; mem_read_i = 0; mem_write_i = 0; mem_to_reg_i = 0; exc_ack_i = 0;
    endtask

    task automatic insn(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] rd,
                        input logic ovf, input logic ten);
        ex_valid_i = 1; ex_pc_i = pc; alu_result_i = res; rd_addr_i = rd;
        alu_overflow_i = ovf; ovf_trap_en_i = ten; reg_write_i = 1; rt_data_i = pc ^ 32'hA5A5_0000;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        idle();
        rst_n = 0;
        #12;
        chk("rst_valid", mem_valid_o, 0);
        chk("rst_result", mem_alu_result_o, 0);
        chk("rst_exc", exc_o, 0);
        chk("rst_epc", epc_o, 0);
        chk("rst_pending", exc_pending_o, 0);
        step();
        rst_n = 1;

        // pass-through
        insn(32'h100, 32'h0000_1234, 5'd5, 0, 0);
        step();
        chk("pt_valid", mem_valid_o, 1);
        chk("pt_result", mem_alu_result_o, 32'h1234);
        chk("pt_rd", mem_rd_addr_o, 5);
        chk("pt_regwr", mem_reg_write_o, 1);
        chk("pt_wdata", mem_wdata_o, 32'h100 ^ 32'hA5A5_0000);

        // signed overflow trap
        insn(32'h0040_0010, 32'h8000_0000, 5'd6, 1, 1);
        step();
        chk("trap_exc", exc_o, 1);
        chk("trap_epc", epc_o, 32'h0040_0010);
        chk("trap_valid", mem_valid_o, 0);
        chk("trap_regwr", mem_reg_write_o, 0);
        chk("trap_pending", exc_pending_o, 1);
        for (int i = 0; i < 3; i++) begin
            insn(32'h0040_0014 + 4 * i, 32'h10 + i, 5'd7, 0, 0);
            exc_ack_i = (i == 2);
            step();
            chk("sq_valid", mem_valid_o, 0);
            chk("sq_exc", exc_o, 0);
            chk("sq_pending", exc_pending_o, (i == 2) ? 0 : 1);
        end
        exc_ack_i = 0;
        insn(32'h0040_0020, 32'h0000_0abc, 5'd8, 0, 0);
        step();
        chk("post_valid", mem_valid_o, 1);
        chk("post_result", mem_alu_result_o, 32'habc);

        // unsigned overflow passes
        insn(32'h200, 32'h8000_0000, 5'd9, 1, 0);
        step();
        chk("addu_result", mem_alu_result_o, 32'h8000_0000);
        chk("addu_regwr", mem_reg_write_o, 1);
        chk("addu_exc", exc_o, 0);
        chk("addu_pending", exc_pending_o, 0);

        // stall holds everything
        insn(32'h300, 32'h0000_1111, 5'd3, 0, 0);
        step();
        stall_i = 1;
        insn(32'h304, 32'h0000_2222, 5'd4, 0, 0);
        step();
        insn(32'h308, 32'h0000_3333, 5'd10, 1, 1);
        step();
        chk("stall_result", mem_alu_result_o, 32'h1111);
        chk("stall_rd", mem_rd_addr_o, 3);
        chk("stall_valid", mem_valid_o, 1);
        chk("stall_exc", exc_o, 0);
        chk("stall_pending", exc_pending_o, 0);
        // flush + stall + trapping input -> bubble, no trap
        flush_i = 1;
        step();
        chk("flush_valid", mem_valid_o, 0);
        chk("flush_regwr", mem_reg_write_o, 0);
        chk("flush_exc", exc_o, 0);
        chk("flush_pending", exc_pending_o, 0);
        chk("flush_epc", epc_o, 32'h0040_0010);
        idle();

        // ack coincident with valid input in TRAP
        insn(32'h500, 32'h8000_0000, 5'd11, 1, 1);
        step();
        chk("t2_exc", exc_o, 1);
        chk("t2_epc", epc_o, 32'h500);
        insn(32'h504, 32'h0000_4444, 5'd12, 0, 0);
        exc_ack_i = 1;
        step();
        chk("ack_valid", mem_valid_o, 0);
        chk("ack_pending", exc_pending_o, 0);
        exc_ack_i = 0;
        insn(32'h508, 32'h0000_5555, 5'd7, 0, 0);
        step();
        chk("ack_next_valid", mem_valid_o, 1);
        chk("ack_next_result", mem_alu_result_o, 32'h5555);
        chk("ack_next_rd", mem_rd_addr_o, 7);

        // async reset in the middle of a trap
        insn(32'h600, 32'h8000_0000, 5'd1, 1, 1);
        step();
        chk("t3_pending", exc_pending_o, 1);
        idle();
        #2;
        rst_n = 0;
        #1;
        chk("arst_pending", exc_pending_o, 0);
        chk("arst_epc", epc_o, 0);
        chk("arst_exc", exc_o, 0);
        #1;
        rst_n = 1;
        step();
        chk("arst_after_pending", exc_pending_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
